// File: rtl/kftvga.sv
// kftvga: 80x30 text-mode VGA controller, 640x480@60 with 8x16 glyphs and a 16-colour palette.
// Optional KFTVGA_BLINK_EN: attribute bit 7 becomes blink, driven by a 6-bit frame counter.
module kftvga (
  input  logic        clock,
  input  logic        reset,
  input  logic        video_clock,
  input  logic        video_reset,
  input  logic        chip_select_n,
  input  logic        read_enable_n,
  input  logic        write_enable_n,
  input  logic [13:0] address,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_bus_out,
  output logic        video_h_sync,
  output logic        video_v_sync,
  output logic [3:0]  video_r,
  output logic [3:0]  video_g,
  output logic [3:0]  video_b
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] HS_START = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;

  // Code and attribute live in separate arrays so the scan reads a whole cell at once.
  logic [7:0] vram_code [0:2399];
  logic [7:0] vram_attr [0:2399];
  logic [7:0] font_ram  [0:4095];

  // ---------------- bus domain ----------------
  logic        bus_wr, bus_rd;
  logic        vram_hit, font_hit, ctrl_hit;
  logic [11:0] bus_cell;
  logic [11:0] bus_font;
  logic [7:0]  rd_data;
  logic [7:0]  data_bus_out_d, data_bus_out_q;
  logic        ctrl_en_d, ctrl_en_q;

  always_comb begin
    bus_wr   = !chip_select_n && !write_enable_n;
    bus_rd   = !chip_select_n && !read_enable_n;
    vram_hit = address < 14'h12C0;
    font_hit = address[13:12] == 2'b10;
    ctrl_hit = address == 14'h3000;
    bus_cell = address[12:1];
    bus_font = address[11:0];
  end

  always_ff @(posedge clock) begin
    if (bus_wr && vram_hit) begin
      if (address[0]) vram_attr[bus_cell] <= data_bus_in;
      else            vram_code[bus_cell] <= data_bus_in;
    end
    if (bus_wr && font_hit) font_ram[bus_font] <= data_bus_in;
  end

  always_comb begin
    rd_data = '0;
    if (vram_hit)      rd_data = address[0] ? vram_attr[bus_cell] : vram_code[bus_cell];
    else if (font_hit) rd_data = font_ram[bus_font];
    else if (ctrl_hit) rd_data = {7'b0, ctrl_en_q};
  end

  // Registered read samples the array before this edge's write lands: old data on read+write.
  always_comb begin
    data_bus_out_d = bus_rd ? rd_data : data_bus_out_q;
    ctrl_en_d      = (bus_wr && ctrl_hit) ? data_bus_in[0] : ctrl_en_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_bus_out_q <= '0;
      ctrl_en_q      <= 1'b1;
    end else begin
      data_bus_out_q <= data_bus_out_d;
      ctrl_en_q      <= ctrl_en_d;
    end
  end

  assign data_bus_out = data_bus_out_q;

  // ---------------- video domain ----------------
  logic [9:0]  h_d, h_q, v_d, v_q;
  logic        vis0, hs0, vs0;
  logic [11:0] vid_cell;
  logic        en_meta_d, en_meta_q, en_sync_d, en_sync_q;
  // stage 1: cell fetch
  logic [7:0]  code1_d, code1_q, attr1_d, attr1_q;
  logic [2:0]  sub1_d, sub1_q;
  logic [3:0]  vrow1_d, vrow1_q;
  logic        vis1_d, vis1_q, hs1_d, hs1_q, vs1_d, vs1_q;
  // stage 2: glyph fetch
  logic [7:0]  font2_d, font2_q, attr2_d, attr2_q;
  logic [2:0]  sub2_d, sub2_q;
  logic        vis2_d, vis2_q, hs2_d, hs2_q, vs2_d, vs2_q;
  // stage 3: output register
  logic [11:0] rgb_d, rgb_q;
  logic        hs_d, hs_q, vs_d, vs_q;
  logic        pix_bit;
  logic [3:0]  fg_idx, bg_idx, col_idx;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] base;
    base = idx[3] ? 4'h5 : 4'h0;
    return {(idx[2] ? 4'hA : 4'h0) + base,
            (idx[1] ? 4'hA : 4'h0) + base,
            (idx[0] ? 4'hA : 4'h0) + base};
  endfunction

`ifdef KFTVGA_BLINK_EN
  logic [5:0] frame_d, frame_q;

  always_comb begin
    frame_d = frame_q;
    if (h_q == H_LAST && v_q == V_LAST) frame_d = frame_q + 6'd1;
  end

  always_ff @(posedge video_clock or posedge video_reset) begin
    if (video_reset) frame_q <= '0;
    else             frame_q <= frame_d;
  end
`endif

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;

    vis0     = (h_q < H_VIS) && (v_q < V_VIS);
    hs0      = !((h_q >= HS_START) && (h_q <= HS_END));
    vs0      = !((v_q >= VS_START) && (v_q <= VS_END));
    vid_cell = vis0 ? 12'(v_q[9:4]) * 12'd80 + 12'(h_q[9:3]) : '0;

    en_meta_d = ctrl_en_q;
    en_sync_d = en_meta_q;

    code1_d = vram_code[vid_cell];
    attr1_d = vram_attr[vid_cell];
    sub1_d  = h_q[2:0];
    vrow1_d = v_q[3:0];
    vis1_d  = vis0;
    hs1_d   = hs0;
    vs1_d   = vs0;

    font2_d = font_ram[{code1_q, vrow1_q}];
    attr2_d = attr1_q;
    sub2_d  = sub1_q;
    vis2_d  = vis1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;

    pix_bit = font2_q[3'd7 - sub2_q];
    fg_idx  = attr2_q[3:0];
`ifdef KFTVGA_BLINK_EN
    bg_idx  = {1'b0, attr2_q[6:4]};
    if (attr2_q[7] && frame_q[5]) pix_bit = 1'b0;
`else
    bg_idx  = attr2_q[7:4];
`endif
    col_idx = pix_bit ? fg_idx : bg_idx;
    rgb_d   = (vis2_q && en_sync_q) ? palette(col_idx) : '0;
    hs_d    = hs2_q;
    vs_d    = vs2_q;
  end

  always_ff @(posedge video_clock or posedge video_reset) begin
    if (video_reset) begin
      h_q       <= '0;
      v_q       <= '0;
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
      code1_q   <= '0;
      attr1_q   <= '0;
      sub1_q    <= '0;
      vrow1_q   <= '0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      font2_q   <= '0;
      attr2_q   <= '0;
      sub2_q    <= '0;
      vis2_q    <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      en_meta_q <= en_meta_d;
      en_sync_q <= en_sync_d;
      code1_q   <= code1_d;
      attr1_q   <= attr1_d;
      sub1_q    <= sub1_d;
      vrow1_q   <= vrow1_d;
      vis1_q    <= vis1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      font2_q   <= font2_d;
      attr2_q   <= attr2_d;
      sub2_q    <= sub2_d;
      vis2_q    <= vis2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign video_h_sync = hs_q;
  assign video_v_sync = vs_q;
  assign video_r      = rgb_q[11:8];
  assign video_g      = rgb_q[7:4];
  assign video_b      = rgb_q[3:0];

endmodule

// File: tb/tb_kftvga.sv
// Scoreboard bench for kftvga: bus reads and scanned pixels/syncs are checked by separate monitors.
module tb_kftvga;

  logic        clock = 1'b0, reset = 1'b1;
  logic        video_clock = 1'b0, video_reset = 1'b1;
  logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [13:0] address = '0;
  logic [7:0]  din = '0;
  logic [7:0]  data_bus_out;
  logic        video_h_sync, video_v_sync;
  logic [3:0]  video_r, video_g, video_b;

  kftvga dut (
    .clock(clock), .reset(reset), .video_clock(video_clock), .video_reset(video_reset),
    .chip_select_n(cs_n), .read_enable_n(rd_n), .write_enable_n(wr_n),
    .address(address), .data_bus_in(din), .data_bus_out(data_bus_out),
    .video_h_sync(video_h_sync), .video_v_sync(video_v_sync),
    .video_r(video_r), .video_g(video_g), .video_b(video_b)
  );

  always #10 clock = ~clock;
  always #5  video_clock = ~video_clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_rgb = 1'b0;

  // ---------- bus scoreboard ----------
  logic [7:0] bus_exp_q[$];
  string      bus_name_q[$];
  bit         rd_pend = 1'b0;
  logic [7:0] b_exp;
  string      b_name;

  task automatic bus_cycle(input logic [13:0] a, input logic [7:0] d, input bit wr, input bit rd,
                           input logic [7:0] exp, input string nm);
    @(negedge clock);
    address = a; din = d; cs_n = 1'b0; wr_n = !wr; rd_n = !rd;
    if (rd) begin
      bus_exp_q.push_back(exp);
      bus_name_q.push_back(nm);
    end
  endtask

  task automatic bus_idle();
    @(negedge clock);
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  always @(posedge clock) rd_pend <= !cs_n && !rd_n;

  always @(negedge clock) begin
    if (rd_pend) begin
      n_tests++;
      if (bus_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_read: got %h with no expectation queued", data_bus_out);
      end else begin
        b_exp  = bus_exp_q.pop_front();
        b_name = bus_name_q.pop_front();
        if (data_bus_out !== b_exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", b_name, data_bus_out, b_exp);
        end
      end
    end
  end

  // ---------- video reference timing and scoreboard ----------
  typedef struct { int unsigned h; int unsigned v; logic [11:0] rgb; } pix_t;
  pix_t pix_q[$];

  int unsigned ref_h = 0, ref_v = 0;
  int unsigned dh[3];
  int unsigned dv[3];
  bit          dval[3];
  logic        e_hs, e_vs;
  logic [11:0] e_rgb, got_rgb;

  always @(posedge video_clock or posedge video_reset) begin
    if (video_reset) begin
      ref_h <= 0; ref_v <= 0;
      dval[0] <= 1'b0; dval[1] <= 1'b0; dval[2] <= 1'b0;
    end else begin
      dval[0] <= 1'b1;   dh[0] <= ref_h; dv[0] <= ref_v;
      dval[1] <= dval[0]; dh[1] <= dh[0]; dv[1] <= dv[0];
      dval[2] <= dval[1]; dh[2] <= dh[1]; dv[2] <= dv[1];
      ref_h <= (ref_h == 799) ? 0 : ref_h + 1;
      if (ref_h == 799) ref_v <= (ref_v == 524) ? 0 : ref_v + 1;
    end
  end

  always @(negedge video_clock) begin
    e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
    if (dval[2]) begin
      e_hs = !(dh[2] >= 656 && dh[2] <= 751);
      e_vs = !(dv[2] == 490 || dv[2] == 491);
      if (pix_q.size() > 0 && pix_q[0].h == dh[2] && pix_q[0].v == dv[2]) begin
        e_rgb = pix_q[0].rgb;
        void'(pix_q.pop_front());
      end
    end
    n_tests++;
    if ({video_h_sync, video_v_sync} !== {e_hs, e_vs}) begin
      n_fail++;
      $display("FAIL sync at h=%0d v=%0d valid=%0b: got hs/vs=%b%b expected %b%b",
               dh[2], dv[2], dval[2], video_h_sync, video_v_sync, e_hs, e_vs);
    end
    if (chk_rgb) begin
      got_rgb = {video_r, video_g, video_b};
      n_tests++;
      if (got_rgb !== e_rgb) begin
        n_fail++;
        $display("FAIL rgb at h=%0d v=%0d: got %h expected %h", dh[2], dv[2], got_rgb, e_rgb);
      end
    end
  end

  // Cell 0: code 0x41 attr 0x1F, glyph row 0 = 0x80; cell 1: code 0x42 attr 0x78, glyph 0xF0.
  task automatic push_pixels(input int unsigned rows);
    pix_t p;
    for (int unsigned v = 0; v < rows; v++) begin
      for (int unsigned h = 0; h < 16; h++) begin
        p.h = h; p.v = v;
        if (h < 8)       p.rgb = (v == 0 && h == 0) ? 12'hFFF : 12'h00A;
        else if (h < 12) p.rgb = 12'h555;
        else             p.rgb = 12'hAAA;
        pix_q.push_back(p);
      end
    end
  endtask

  task automatic vreset_pulse();
    @(negedge video_clock);
    #2 video_reset = 1'b1;
  endtask

  task automatic wait_ref(input int unsigned v, input int unsigned h);
    while (!(ref_v == v && ref_h == h)) @(negedge video_clock);
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    #25 reset = 1'b0;
    n_tests++;
    if (data_bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 00", data_bus_out);
    end
    repeat (2) @(negedge video_clock);
    video_reset = 1'b0;

    bus_cycle(14'h3000, 8'h00, 1'b0, 1'b1, 8'h01, "ctrl_reset_value");
    for (int unsigned i = 0; i < 2400; i++)
      bus_cycle(14'(2 * i + 1), 8'h00, 1'b1, 1'b0, 8'h00, "");

    bus_cycle(14'h0000, 8'h41, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h0001, 8'h1F, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h0000, 8'h00, 1'b0, 1'b1, 8'h41, "vram_code0");
    bus_cycle(14'h0001, 8'h00, 1'b0, 1'b1, 8'h1F, "vram_attr0");
    bus_cycle(14'h0002, 8'h42, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h0003, 8'h78, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h0004, 8'h55, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h0004, 8'hAA, 1'b1, 1'b1, 8'h55, "rw_same_cycle_old");
    bus_cycle(14'h0004, 8'h00, 1'b0, 1'b1, 8'hAA, "rw_same_cycle_new");
    bus_cycle(14'h1500, 8'h5A, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h1500, 8'h00, 1'b0, 1'b1, 8'h00, "unmapped_read");
    for (int unsigned r = 0; r < 16; r++) begin
      bus_cycle(14'h2410 + 14'(r), (r == 0) ? 8'h80 : 8'h00, 1'b1, 1'b0, 8'h00, "");
      bus_cycle(14'h2420 + 14'(r), 8'hF0, 1'b1, 1'b0, 8'h00, "");
    end
    bus_cycle(14'h2410, 8'h00, 1'b0, 1'b1, 8'h80, "font_41_row0");
    bus_cycle(14'h242F, 8'h00, 1'b0, 1'b1, 8'hF0, "font_42_row15");
    bus_cycle(14'h3000, 8'hFF, 1'b1, 1'b0, 8'h00, "");
    bus_cycle(14'h3000, 8'h00, 1'b0, 1'b1, 8'h01, "ctrl_upper_bits_zero");
    bus_idle();

    // Restart the scan so the rendered cells are seen from (0,0).
    vreset_pulse();
    push_pixels(16);
    chk_rgb = 1'b1;
    repeat (2) @(negedge video_clock);
    video_reset = 1'b0;

    wait_ref(17, 300);
    vreset_pulse();
    push_pixels(8);
    repeat (2) @(negedge video_clock);
    video_reset = 1'b0;

    wait_ref(7, 700);
    chk_rgb = 1'b0;
    bus_cycle(14'h3000, 8'h00, 1'b1, 1'b0, 8'h00, "");
    bus_idle();
    repeat (10) @(negedge video_clock);
    chk_rgb = 1'b1;

    wait_ref(17, 0);
    bus_cycle(14'h3000, 8'h00, 1'b0, 1'b1, 8'h00, "ctrl_disabled");
    bus_cycle(14'h0001, 8'h00, 1'b0, 1'b1, 8'h1F, "vram_kept_over_vreset");
    bus_idle();
    repeat (3) @(negedge clock);

    n_tests++;
    if (pix_q.size() != 0) begin
      n_fail++;
      $display("FAIL pixel_queue_drained: %0d left, expected 0", pix_q.size());
    end
    n_tests++;
    if (bus_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bus_queue_drained: %0d left, expected 0", bus_exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
